adc_spi_if: RTL and testbench

Serial front-end for an external 12-bit SPI ADC (16-bit frame: 4 leading zeros, then D11..D0, MSB first).
- Sits directly upstream of the acquisition/averaging stage.
- Turns that stage's conversion-request strobe into one CS_n/SCLK frame.
- Returns the sample as a parallel word with a one-cycle ready pulse.

---
 rtl/adc_spi_pkg.sv | 18 +
 rtl/adc_sclk_div.sv | 39 +++
 rtl/adc_spi_if.sv | 179 +++++++++++++++++
 tb/tb_adc_spi_if.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared definitions for the SPI ADC front-end: FSM encoding and frame geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_QUIET = 2'd3
  } adc_state_t;

  // 16-bit frame: LEAD_ZEROS zero bits followed by the sample, MSB first.
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_W_DEF = 12;

endpackage

// File: rtl/adc_sclk_div.sv
// SCLK half-period timer: fires tgl_o once every CLK_DIV cycles while run_i is high.
// Latency: tgl_o/rise_o are combinational from the counter; first tgl_o CLK_DIV cycles after run_i rises.
// Backpressure: none; counter is held at zero whenever run_i is low.
//
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   run_i            : count enable (FSM in SETUP or SHIFT)
//   sclk_i           : current registered SCLK level
//   tgl_o            : half-period elapsed, SCLK should toggle now
//   rise_o           : toggle that takes SCLK from 0 to 1 (sampling edge)
module adc_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic run_i,
  input  logic sclk_i,
  output logic tgl_o,
  output logic rise_o
);

  localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;

  assign tgl_o  = run_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o = tgl_o && !sclk_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (!run_i || tgl_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_if.sv
// SPI master for a 12-bit ADC: one request edge -> one 16-bit CS_n/SCLK frame -> parallel sample + rdy pulse.
// Latency: rdy pulses 33*CLK_DIV cycles after the clock edge that sees the request rise; CS_n then stays high >= max(QUIET_CYC,2) cycles.
// Backpressure: none; request edges arriving while busy_o is high are dropped, a held request never retriggers.
//
// Ports:
//   clk_i, reset_n_i      : clock, asynchronous active-low reset
//   adc_data_req_i        : conversion request, rising-edge triggered
//   adc_data_rdy_o        : one-cycle pulse when adc_data_o is updated
//   adc_data_o            : last sample, held until the next frame completes
//   busy_o                : frame or quiet gap in progress
//   err_o                 : sticky leading-zero error (0 unless ADC_SPI_LEADZERO_CHK_EN is defined)
//   adc_cs_n_o/adc_sclk_o : SPI chip select (active low) and serial clock (idle high)
//   adc_sdata_i           : SPI serial data from the ADC
// Build option: define ADC_SPI_LEADZERO_CHK_EN to build the leading-zero checker.
module adc_spi_if
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int QUIET_CYC = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              adc_data_req_i,
  output logic              adc_data_rdy_o,
  output logic [DATA_W-1:0] adc_data_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              adc_cs_n_o,
  output logic              adc_sclk_o,
  input  logic              adc_sdata_i
);

  // A one-cycle quiet gap would let the next frame's CS_n fall too close to the last one.
  localparam int Q_EFF = (QUIET_CYC < 2) ? 2 : QUIET_CYC;
  localparam int QW    = $clog2(Q_EFF);
  localparam int BW    = $clog2(FRAME_BITS);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("adc_spi_if: CLK_DIV must be >= 2");
    end
  endgenerate

  adc_state_t            state_q, state_d;
  logic                  req_d_q;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [QW-1:0]         qcnt_q, qcnt_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  frame_end;
  logic                  div_run, div_tgl, div_rise;

  assign div_run = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

  adc_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .run_i     (div_run),
    .sclk_i    (sclk_q),
    .tgl_o     (div_tgl),
    .rise_o    (div_rise)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    qcnt_d    = qcnt_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    rdy_d     = 1'b0;
    busy_d    = busy_q;
    data_d    = data_q;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (adc_data_req_i && !req_d_q) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
          busy_d  = 1'b1;
          bit_d   = '0;
        end
      end
      ST_SETUP: begin
        // CS_n-to-first-SCLK-fall setup time of one half period.
        if (div_tgl) begin
          sclk_d  = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_rise) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[FRAME_BITS-2:0], adc_sdata_i};
        end else if (div_tgl) begin
          // End of a high half-period: either start the next bit or close the frame
          // with SCLK left high.
          if (bit_q == BW'(FRAME_BITS - 1)) begin
            frame_end = 1'b1;
            cs_n_d    = 1'b1;
            rdy_d     = 1'b1;
            data_d    = shift_q[DATA_W-1:0];
            qcnt_d    = '0;
            state_d   = ST_QUIET;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      ST_QUIET: begin
        if (qcnt_q == QW'(Q_EFF - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      req_d_q <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
      qcnt_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_d_q <= adc_data_req_i;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      qcnt_q  <= qcnt_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

`ifdef ADC_SPI_LEADZERO_CHK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q <= 1'b0;
    end else if (frame_end && (shift_q[FRAME_BITS-1 -: LEAD_ZEROS] != '0)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic lead_unused;
  assign lead_unused = frame_end ^ (^shift_q[FRAME_BITS-1 -: LEAD_ZEROS]);
  assign err_o       = 1'b0;
`endif

  assign adc_data_rdy_o = rdy_q;
  assign adc_data_o     = data_q;
  assign busy_o         = busy_q;
  assign adc_cs_n_o     = cs_n_q;
  assign adc_sclk_o     = sclk_q;

endmodule

// File: tb/tb_adc_spi_if.sv
// Directed bench for adc_spi_if with a behavioural SPI ADC model.
// Inputs are driven and outputs sampled on the falling clk edge; a monitor
// samples 2 ns after each rising edge to accumulate frame statistics.
module tb_adc_spi_if;

  localparam int CLK_DIV   = 4;
  localparam int QUIET_CYC = 8;
  localparam int LAT       = 33 * CLK_DIV;   // request edge -> rdy edge
`ifdef ADC_SPI_LEADZERO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        rdy;
  logic [11:0] data;
  logic        busy;
  logic        err;
  logic        cs_n;
  logic        sclk;
  logic        sdata = 1'b0;

  adc_spi_if #(.CLK_DIV(CLK_DIV), .DATA_W(12), .QUIET_CYC(QUIET_CYC)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .adc_data_req_i (req),
    .adc_data_rdy_o (rdy),
    .adc_data_o     (data),
    .busy_o         (busy),
    .err_o          (err),
    .adc_cs_n_o     (cs_n),
    .adc_sclk_o     (sclk),
    .adc_sdata_i    (sdata)
  );

  always #5 clk = ~clk;

  // ADC model: each SCLK fall inside a frame presents the next bit, MSB first.
  logic [15:0] adc_word = 16'h0000;
  int          k = 0;
  always @(negedge cs_n) k = 0;
  always @(negedge sclk) begin
    if (cs_n === 1'b0 && k < 16) begin
      sdata = adc_word[15-k];
      k++;
    end
  end

  // Frame statistics.
  int cyc = 0, cs_low = 0, rises = 0, rdy_cnt = 0, rdy_cyc = 0;
  int hi_run = 0, last_gap = 0;
  logic sclk_prev = 1'b1;
  always @(posedge clk) begin
    cyc++;
    #2;
    if (cs_n === 1'b0) begin
      cs_low++;
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end else begin
      hi_run++;
    end
    if (sclk === 1'b1 && sclk_prev === 1'b0) rises++;
    sclk_prev = sclk;
    if (rdy === 1'b1) begin
      rdy_cnt++;
      rdy_cyc = cyc;
    end
  end

  int tests = 0, fails = 0;
  int req_cyc = 0, base_cs = 0, base_rise = 0, base_rdy = 0;
  int idle_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; request is high for 'hold' rising edges.
  task automatic start_frame(input logic [15:0] w, input int hold);
    adc_word  = w;
    base_cs   = cs_low;
    base_rise = rises;
    base_rdy  = rdy_cnt;
    req       = 1'b1;
    req_cyc   = cyc + 1;
    repeat (hold) @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 400), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset values, then 50 idle cycles with no request.
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_rdy",  32'(rdy),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data), 32'h000);
    chk("rst_err",  32'(err),  32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b1 || rdy !== 1'b0 || busy !== 1'b0 ||
          data !== 12'h000 || err !== 1'b0) idle_bad++;
    end
    chk("idle_50_cycles_bad", 32'(idle_bad), 32'd0);

    // 2: single frame 0x0A5C.
    start_frame(16'h0A5C, 2);
    wait_idle("t2_timeout");
    chk("t2_sclk_rises", 32'(rises - base_rise), 32'd16);
    chk("t2_cs_low_cyc", 32'(cs_low - base_cs), 32'd132);
    chk("t2_rdy_cycles", 32'(rdy_cnt - base_rdy), 32'd1);
    chk("t2_latency",    32'(rdy_cyc - req_cyc), 32'(LAT));
    chk("t2_data",       32'(data), 32'hA5C);
    chk("t2_err",        32'(err), 32'd0);

    // 3a: extra request pulses around frame cycles 20 and 120 are ignored.
    repeat (2) @(negedge clk);
    start_frame(16'h0555, 2);
    repeat (17) @(negedge clk);
    req = 1'b1;
    repeat (2) @(negedge clk);
    req = 1'b0;
    repeat (96) @(negedge clk);
    req = 1'b1;
    repeat (2) @(negedge clk);
    req = 1'b0;
    wait_idle("t3a_timeout");
    repeat (10) @(negedge clk);
    chk("t3a_rdy_cycles", 32'(rdy_cnt - base_rdy), 32'd1);
    chk("t3a_cs_low_cyc", 32'(cs_low - base_cs), 32'd132);
    chk("t3a_data",       32'(data), 32'h555);

    // 3b: request held high 200 cycles -> exactly one frame.
    start_frame(16'h0AAA, 200);
    wait_idle("t3b_timeout");
    repeat (10) @(negedge clk);
    chk("t3b_rdy_cycles", 32'(rdy_cnt - base_rdy), 32'd1);
    chk("t3b_cs_low_cyc", 32'(cs_low - base_cs), 32'd132);
    chk("t3b_data",       32'(data), 32'hAAA);
    chk("t3b_busy",       32'(busy), 32'd0);

    // 4: reset mid-frame while SCLK is low (frame cycle 62).
    start_frame(16'h0FFF, 2);
    repeat (60) @(negedge clk);
    chk("t4_sclk_low_before", 32'(sclk), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t4_cs_n_async", 32'(cs_n), 32'd1);
    chk("t4_sclk_async", 32'(sclk), 32'd1);
    chk("t4_busy_async", 32'(busy), 32'd0);
    chk("t4_data_async", 32'(data), 32'h000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_no_rdy", 32'(rdy_cnt - base_rdy), 32'd0);
    start_frame(16'h0123, 2);
    wait_idle("t4_timeout");
    chk("t4_data_after",  32'(data), 32'h123);
    chk("t4_rdy_cycles",  32'(rdy_cnt - base_rdy), 32'd1);
    chk("t4_latency",     32'(rdy_cyc - req_cyc), 32'(LAT));

    // 5: back-to-back frames, second request on the first busy=0 cycle.
    repeat (3) @(negedge clk);
    start_frame(16'h0FFF, 2);
    wait_idle("t5a_timeout");
    chk("t5a_data", 32'(data), 32'hFFF);
    chk("t5a_busy", 32'(busy), 32'd0);
    start_frame(16'h0001, 2);
    wait_idle("t5b_timeout");
    chk("t5b_data",     32'(data), 32'h001);
    chk("t5b_latency",  32'(rdy_cyc - req_cyc), 32'(LAT));
    chk("t5_cs_gap",    32'(last_gap), 32'(QUIET_CYC + 1));
    chk("t5b_sclk_rises", 32'(rises - base_rise), 32'd16);

    // 6: non-zero leading nibble; err is sticky only when the checker is built.
    repeat (3) @(negedge clk);
    start_frame(16'h8ABC, 2);
    wait_idle("t6a_timeout");
    chk("t6a_data",       32'(data), 32'hABC);
    chk("t6a_err",        32'(err), 32'(CHK));
    chk("t6a_rdy_cycles", 32'(rdy_cnt - base_rdy), 32'd1);
    repeat (3) @(negedge clk);
    start_frame(16'h0321, 2);
    wait_idle("t6b_timeout");
    chk("t6b_data", 32'(data), 32'h321);
    chk("t6b_err_sticky", 32'(err), 32'(CHK));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
